// File: rtl/axi4_lite_if.sv
// rtl/axi4_lite_if.sv - AXI4-Lite bus bundle with master and slave views
interface axi4_lite_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wvalid;
  logic                    wready;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic                    arvalid;
  logic                    arready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rvalid;
  logic                    rready;

  modport master (
    output awaddr, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input bresp, bvalid, output bready,
    output araddr, arvalid, input arready,
    input rdata, rresp, rvalid, output rready
  );

  modport slave (
    input awaddr, awvalid, output awready,
    input wdata, wstrb, wvalid, output wready,
    output bresp, bvalid, input bready,
    input araddr, arvalid, output arready,
    output rdata, rresp, rvalid, input rready
  );
endinterface

// File: rtl/axi4_lite_slave_adapter.sv
// rtl/axi4_lite_slave_adapter.sv - AXI4-Lite slave to simple strobe/valid register backend
module axi4_lite_slave_adapter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int RD_TIMEOUT = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  axi4_lite_if.slave              axi4_lite_i,
  output logic [ADDR_WIDTH-1:0]   wr_addr_o,
  output logic [DATA_WIDTH-1:0]   wr_data_o,
  output logic [DATA_WIDTH/8-1:0] wr_be_o,
  output logic                    wr_stb_o,
  output logic [ADDR_WIDTH-1:0]   rd_addr_o,
  output logic                    rd_stb_o,
  input  logic [DATA_WIDTH-1:0]   rd_data_i,
  input  logic                    rd_valid_i,
  output logic                    busy_o
);
  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int CNT_W  = $clog2(RD_TIMEOUT) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RD_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  generate
    if (DATA_WIDTH != 32 && DATA_WIDTH != 64) begin : g_bad_data_width
      $error("axi4_lite_slave_adapter: DATA_WIDTH must be 32 or 64");
    end
    if (RD_TIMEOUT < 2) begin : g_bad_rd_timeout
      $error("axi4_lite_slave_adapter: RD_TIMEOUT must be at least 2");
    end
  endgenerate

  typedef enum logic [2:0] {
    IDLE_S,
    WAIT_W_S,
    WAIT_AW_S,
    WR_S,
    BRESP_S,
    RD_S,
    RD_WAIT_S,
    RRESP_S
  } state_t;

  state_t                  state_q;
  logic [CNT_W-1:0]        cnt_q;
  logic [ADDR_WIDTH-1:0]   wr_addr_q;
  logic [DATA_WIDTH-1:0]   wr_data_q;
  logic [STRB_W-1:0]       wr_be_q;
  logic [ADDR_WIDTH-1:0]   rd_addr_q;
  logic [DATA_WIDTH-1:0]   rdata_q;
  logic [1:0]              rresp_q;

  logic aw_rdy;
  logic w_rdy;
  logic ar_rdy;
  logic aw_hs;
  logic w_hs;
  logic ar_hs;

  // Readies are the only outputs allowed to look at the incoming valids;
  // a read is held off whenever any write channel is presenting.
  always_comb begin
    aw_rdy = 1'b0;
    w_rdy  = 1'b0;
    ar_rdy = 1'b0;
    if (!rst_i) begin
      case (state_q)
        IDLE_S: begin
          aw_rdy = 1'b1;
          w_rdy  = 1'b1;
          ar_rdy = !axi4_lite_i.awvalid && !axi4_lite_i.wvalid;
        end
        WAIT_W_S:  w_rdy  = 1'b1;
        WAIT_AW_S: aw_rdy = 1'b1;
        default: begin
          aw_rdy = 1'b0;
          w_rdy  = 1'b0;
          ar_rdy = 1'b0;
        end
      endcase
    end
  end

  assign aw_hs = axi4_lite_i.awvalid && aw_rdy;
  assign w_hs  = axi4_lite_i.wvalid  && w_rdy;
  assign ar_hs = axi4_lite_i.arvalid && ar_rdy;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE_S;
      cnt_q     <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      wr_be_q   <= '0;
      rd_addr_q <= '0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
    end else begin
      case (state_q)
        IDLE_S: begin
          if (aw_hs) begin
            wr_addr_q <= axi4_lite_i.awaddr;
          end
          if (w_hs) begin
            wr_data_q <= axi4_lite_i.wdata;
            wr_be_q   <= axi4_lite_i.wstrb;
          end
          if (aw_hs && w_hs) begin
            state_q <= WR_S;
          end else if (aw_hs) begin
            state_q <= WAIT_W_S;
          end else if (w_hs) begin
            state_q <= WAIT_AW_S;
          end else if (ar_hs) begin
            rd_addr_q <= axi4_lite_i.araddr;
            state_q   <= RD_S;
          end
        end
        WAIT_W_S: begin
          if (w_hs) begin
            wr_data_q <= axi4_lite_i.wdata;
            wr_be_q   <= axi4_lite_i.wstrb;
            state_q   <= WR_S;
          end
        end
        WAIT_AW_S: begin
          if (aw_hs) begin
            wr_addr_q <= axi4_lite_i.awaddr;
            state_q   <= WR_S;
          end
        end
        WR_S: begin
          state_q <= BRESP_S;
        end
        BRESP_S: begin
          if (axi4_lite_i.bready) begin
            state_q <= IDLE_S;
          end
        end
        RD_S: begin
          cnt_q   <= '0;
          state_q <= RD_WAIT_S;
        end
        RD_WAIT_S: begin
          // Backend data beats the timeout when both land on the last cycle.
          if (rd_valid_i) begin
            rdata_q <= rd_data_i;
            rresp_q <= RESP_OKAY;
            state_q <= RRESP_S;
          end else begin
            if (cnt_q == CNT_LAST) begin
              rdata_q <= '0;
              rresp_q <= RESP_SLVERR;
              state_q <= RRESP_S;
            end
            if (cnt_q != CNT_MAX) begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        RRESP_S: begin
          if (axi4_lite_i.rready) begin
            state_q <= IDLE_S;
          end
        end
        default: begin
          state_q <= IDLE_S;
        end
      endcase
    end
  end

  assign axi4_lite_i.awready = aw_rdy;
  assign axi4_lite_i.wready  = w_rdy;
  assign axi4_lite_i.arready = ar_rdy;
  assign axi4_lite_i.bvalid  = (state_q == BRESP_S);
  assign axi4_lite_i.bresp   = RESP_OKAY;
  assign axi4_lite_i.rvalid  = (state_q == RRESP_S);
  assign axi4_lite_i.rdata   = rdata_q;
  assign axi4_lite_i.rresp   = rresp_q;

  assign wr_addr_o = wr_addr_q;
  assign wr_data_o = wr_data_q;
  assign wr_be_o   = wr_be_q;
  assign wr_stb_o  = (state_q == WR_S);
  assign rd_addr_o = rd_addr_q;
  assign rd_stb_o  = (state_q == RD_S);
  assign busy_o    = (state_q != IDLE_S);
endmodule

// File: tb/tb_axi4_lite_slave_adapter.sv
// tb/tb_axi4_lite_slave_adapter.sv - randomized self-checking bench for axi4_lite_slave_adapter
module tb_axi4_lite_slave_adapter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int T  = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic [3:0]    wr_be;
  logic          wr_stb;
  logic [AW-1:0] rd_addr;
  logic          rd_stb;
  logic [DW-1:0] rd_data = '0;
  logic          rd_valid = 1'b0;
  logic          busy;
  int n_cmp = 0;
  int n_err = 0;

  axi4_lite_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  axi4_lite_slave_adapter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RD_TIMEOUT(T)) dut (
    .clk_i(clk), .rst_i(rst), .axi4_lite_i(bus),
    .wr_addr_o(wr_addr), .wr_data_o(wr_data), .wr_be_o(wr_be), .wr_stb_o(wr_stb),
    .rd_addr_o(rd_addr), .rd_stb_o(rd_stb), .rd_data_i(rd_data), .rd_valid_i(rd_valid),
    .busy_o(busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_bus();
    bus.awvalid = 0; bus.awaddr = '0; bus.wvalid = 0; bus.wdata = '0; bus.wstrb = '0;
    bus.bready = 0; bus.arvalid = 0; bus.araddr = '0; bus.rready = 0;
    rd_valid = 0; rd_data = '0;
  endtask

  // Expected: each write channel is accepted the first cycle it is offered,
  // one wr_stb pulse follows the later handshake, bvalid the cycle after.
  task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          input int aw_d, input int w_d, input int b_d, input bit ar_mean,
                          input string tag);
    bit aw_done, w_done, hs_aw, hs_w;
    int c;
    aw_done = 0; w_done = 0; c = 0;
    while (!(aw_done && w_done) && c < 40) begin
      bus.awvalid = !aw_done && (c >= aw_d);
      bus.awaddr  = bus.awvalid ? addr : $urandom;
      bus.wvalid  = !w_done && (c >= w_d);
      bus.wdata   = bus.wvalid ? data : $urandom;
      bus.wstrb   = bus.wvalid ? strb : 4'($urandom);
      bus.arvalid = ar_mean && (aw_done || w_done);
      bus.araddr  = $urandom;
      @(negedge clk);
      n_cmp++;
      if ((bus.awvalid && bus.awready !== 1'b1) || (bus.wvalid && bus.wready !== 1'b1)) begin
        n_err++;
        $display("FAIL %s accept: awready=%b wready=%b required 1 for offered channels", tag, bus.awready, bus.wready);
      end
      n_cmp++;
      if (wr_stb !== 1'b0) begin
        n_err++;
        $display("FAIL %s early_stb: wr_stb=%b required 0", tag, wr_stb);
      end
      if (bus.arvalid) begin
        n_cmp++;
        if (bus.arready !== 1'b0) begin
          n_err++;
          $display("FAIL %s arready_blocked: arready=%b required 0", tag, bus.arready);
        end
      end
      hs_aw = bus.awvalid && bus.awready;
      hs_w  = bus.wvalid && bus.wready;
      step();
      aw_done = aw_done || hs_aw;
      w_done  = w_done || hs_w;
      c++;
    end
    if (!(aw_done && w_done)) begin
      n_cmp++; n_err++;
      $display("FAIL %s handshake_timeout: aw_done=%b w_done=%b required 1 1", tag, aw_done, w_done);
    end
    bus.awvalid = 0; bus.wvalid = 0; bus.arvalid = 0;
    @(negedge clk);
    n_cmp++;
    if ({wr_stb, wr_addr, wr_data, wr_be} !== {1'b1, addr, data, strb}) begin
      n_err++;
      $display("FAIL %s wr_stb: stb/addr/data/be=%b %h %h %h required 1 %h %h %h",
               tag, wr_stb, wr_addr, wr_data, wr_be, addr, data, strb);
    end
    n_cmp++;
    if (bus.bvalid !== 1'b0) begin
      n_err++;
      $display("FAIL %s early_bvalid: bvalid=%b required 0", tag, bus.bvalid);
    end
    step();
    for (int i = 0; i <= b_d; i++) begin
      bus.bready = (i == b_d);
      @(negedge clk);
      n_cmp++;
      if ({bus.bvalid, bus.bresp, wr_stb} !== {1'b1, 2'b00, 1'b0}) begin
        n_err++;
        $display("FAIL %s bresp_hold[%0d]: bvalid=%b bresp=%b stb=%b required 1 00 0",
                 tag, i, bus.bvalid, bus.bresp, wr_stb);
      end
      step();
    end
    bus.bready = 0;
    @(negedge clk);
    n_cmp++;
    if ({bus.bvalid, busy} !== 2'b00) begin
      n_err++;
      $display("FAIL %s write_done: bvalid=%b busy=%b required 0 0", tag, bus.bvalid, busy);
    end
    step();
  endtask

  // d = RD_WAIT cycle (1-based) on which the backend pulses rd_valid; 0 = never.
  // Expected: data if 1 <= d <= T, otherwise zero data with SLVERR after T cycles.
  task automatic do_read(input logic [31:0] addr, input logic [31:0] data, input int d,
                         input int rr_d, input string tag);
    int ek, k;
    bit hit;
    logic [31:0] edata;
    logic [1:0] eresp;
    hit   = (d >= 1) && (d <= T);
    ek    = hit ? d : T;
    edata = hit ? data : 32'h0;
    eresp = hit ? 2'b00 : 2'b10;
    bus.arvalid = 1; bus.araddr = addr;
    @(negedge clk);
    n_cmp++;
    if (bus.arready !== 1'b1) begin
      n_err++;
      $display("FAIL %s arready: arready=%b required 1", tag, bus.arready);
      bus.arvalid = 0;
      step();
      return;
    end
    step();
    bus.arvalid = 0; bus.araddr = $urandom;
    @(negedge clk);
    n_cmp++;
    if ({rd_stb, rd_addr, bus.rvalid} !== {1'b1, addr, 1'b0}) begin
      n_err++;
      $display("FAIL %s rd_stb: stb/addr/rvalid=%b %h %b required 1 %h 0", tag, rd_stb, rd_addr, bus.rvalid, addr);
    end
    step();
    for (k = 1; k <= ek; k++) begin
      rd_valid = (k == d);
      rd_data  = (k == d) ? data : $urandom;
      @(negedge clk);
      n_cmp++;
      if ({bus.rvalid, rd_stb} !== 2'b00) begin
        n_err++;
        $display("FAIL %s wait[%0d]: rvalid=%b rd_stb=%b required 0 0", tag, k, bus.rvalid, rd_stb);
      end
      step();
    end
    for (int j = 0; j <= rr_d; j++) begin
      k = ek + 1 + j;
      rd_valid = (k == d);
      rd_data  = $urandom;
      bus.rready = (j == rr_d);
      @(negedge clk);
      n_cmp++;
      if ({bus.rvalid, bus.rdata, bus.rresp} !== {1'b1, edata, eresp}) begin
        n_err++;
        $display("FAIL %s rresp[%0d]: rvalid/rdata/rresp=%b %h %b required 1 %h %b",
                 tag, j, bus.rvalid, bus.rdata, bus.rresp, edata, eresp);
      end
      step();
    end
    rd_valid = 0; bus.rready = 0;
    @(negedge clk);
    n_cmp++;
    if ({bus.rvalid, busy} !== 2'b00) begin
      n_err++;
      $display("FAIL %s read_done: rvalid=%b busy=%b required 0 0", tag, bus.rvalid, busy);
    end
    step();
  endtask

  task automatic test_reset();
    rst = 1;
    bus.awvalid = 1; bus.wvalid = 1; bus.arvalid = 1; rd_valid = 1;
    step();
    step();
    @(negedge clk);
    n_cmp++;
    if ({bus.awready, bus.wready, bus.arready, bus.bvalid, bus.rvalid, wr_stb, rd_stb, busy} !== 8'h00) begin
      n_err++;
      $display("FAIL reset_ctrl: aw/w/ar rdy, bvalid, rvalid, wr_stb, rd_stb, busy=%b%b%b%b%b%b%b%b required 00000000",
               bus.awready, bus.wready, bus.arready, bus.bvalid, bus.rvalid, wr_stb, rd_stb, busy);
    end
    n_cmp++;
    if ({wr_addr, wr_data, wr_be, rd_addr, bus.rdata, bus.rresp, bus.bresp} !== '0) begin
      n_err++;
      $display("FAIL reset_data: wr_addr=%h wr_data=%h be=%h rd_addr=%h rdata=%h rresp=%b bresp=%b required 0",
               wr_addr, wr_data, wr_be, rd_addr, bus.rdata, bus.rresp, bus.bresp);
    end
    step();
    idle_bus();
    rst = 0;
    @(negedge clk);
    n_cmp++;
    if ({bus.awready, bus.wready, bus.arready, busy} !== 4'b1110) begin
      n_err++;
      $display("FAIL idle_readies: aw/w/ar/busy=%b%b%b%b required 1110", bus.awready, bus.wready, bus.arready, busy);
    end
    step();
  endtask

  task automatic test_collision();
    bus.awvalid = 1; bus.awaddr = 32'h50; bus.wvalid = 1; bus.wdata = 32'hA5A5_0F0F; bus.wstrb = 4'hC;
    bus.arvalid = 1; bus.araddr = 32'h48;
    @(negedge clk);
    n_cmp++;
    if ({bus.awready, bus.wready, bus.arready} !== 3'b110) begin
      n_err++;
      $display("FAIL coll_readies: aw/w/ar=%b%b%b required 110", bus.awready, bus.wready, bus.arready);
    end
    step();
    bus.awvalid = 0; bus.wvalid = 0;
    @(negedge clk);
    n_cmp++;
    if ({wr_stb, wr_addr, wr_data, wr_be, bus.arready} !== {1'b1, 32'h50, 32'hA5A5_0F0F, 4'hC, 1'b0}) begin
      n_err++;
      $display("FAIL coll_write: stb/addr/data/be/arready=%b %h %h %h %b required 1 00000050 a5a50f0f c 0",
               wr_stb, wr_addr, wr_data, wr_be, bus.arready);
    end
    step();
    bus.bready = 1;
    @(negedge clk);
    n_cmp++;
    if ({bus.bvalid, bus.arready, bus.rvalid} !== 3'b100) begin
      n_err++;
      $display("FAIL coll_bresp: bvalid/arready/rvalid=%b%b%b required 100", bus.bvalid, bus.arready, bus.rvalid);
    end
    step();
    bus.bready = 0;
    do_read(32'h48, 32'h1357_9BDF, 2, 1, "coll_read");
  endtask

  task automatic test_reset_mid_read();
    bus.arvalid = 1; bus.araddr = 32'h60;
    step();
    bus.arvalid = 0;
    step();
    step();
    step();
    rst = 1;
    step();
    rst = 0;
    @(negedge clk);
    n_cmp++;
    if ({bus.bvalid, bus.rvalid, wr_stb, rd_stb, busy} !== 5'b00000) begin
      n_err++;
      $display("FAIL midrst_ctrl: bvalid/rvalid/wr_stb/rd_stb/busy=%b%b%b%b%b required 00000",
               bus.bvalid, bus.rvalid, wr_stb, rd_stb, busy);
    end
    n_cmp++;
    if ({wr_addr, wr_data, wr_be, rd_addr, bus.rdata, bus.rresp} !== '0) begin
      n_err++;
      $display("FAIL midrst_data: wr_addr=%h wr_data=%h be=%h rd_addr=%h rdata=%h rresp=%b required 0",
               wr_addr, wr_data, wr_be, rd_addr, bus.rdata, bus.rresp);
    end
    step();
    for (int i = 0; i < T + 4; i++) begin
      rd_valid = (i == 3);
      rd_data  = $urandom;
      @(negedge clk);
      n_cmp++;
      if ({bus.rvalid, busy} !== 2'b00) begin
        n_err++;
        $display("FAIL midrst_quiet[%0d]: rvalid=%b busy=%b required 0 0", i, bus.rvalid, busy);
      end
      step();
    end
    rd_valid = 0;
    do_write(32'h70, 32'h0BAD_CAFE, 4'h9, 0, 0, 0, 0, "midrst_write");
  endtask

  task automatic test_random();
    for (int i = 0; i < 24; i++) begin
      if ($urandom_range(0, 1) == 1)
        do_write($urandom, $urandom, 4'($urandom_range(1, 15)), int'($urandom_range(0, 3)),
                 int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 0, "rand_wr");
      else
        do_read($urandom, $urandom, int'($urandom_range(0, T + 3)), int'($urandom_range(0, 3)), "rand_rd");
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_bus();
    test_reset();
    do_write(32'h10, 32'hDEAD_BEEF, 4'hF, 0, 0, 3, 0, "simul_write");
    do_write(32'h20, 32'h1234_5678, 4'h3, 4, 0, 0, 1, "w_first");
    do_write(32'h24, 32'h8765_4321, 4'h6, 0, 2, 1, 1, "aw_first");
    do_read(32'h40, 32'hCAFE_F00D, 3, 0, "read_data");
    do_read(32'h44, 32'hFFFF_FFFF, T + 2, 4, "read_timeout");
    do_read(32'h4C, 32'h600D_DA7A, T, 1, "data_last_cycle");
    do_read(32'h4C, 32'h7777_7777, T + 1, 0, "data_after_timeout");
    test_collision();
    test_reset_mid_read();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/axi4_lite_slave_adapter.md
AXI4_LITE_SLAVE_ADAPTER -- requirements
Module: axi4_lite_slave_adapter

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, AXI and local data width; the only legal values are 32 and 64.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 32, AXI and local address width.
REQ-003 The block SHALL have parameter RD_TIMEOUT, default 16, the maximum number of cycles spent waiting for read data; the legal range is >= 2.
REQ-004 The block SHALL have port clk_i, input, 1 bit: the single clock; all logic SHALL be on its rising edge.
REQ-005 The block SHALL have port rst_i, input, 1 bit: reset, synchronous and active-high.
REQ-006 The block SHALL have port axi4_lite_i, an axi4_lite_if.slave modport: the AXI4-Lite slave port.
REQ-007 The block SHALL have port wr_addr_o, output, ADDR_WIDTH bits: the captured write address.
REQ-008 The block SHALL have port wr_data_o, output, DATA_WIDTH bits: the captured write data.
REQ-009 The block SHALL have port wr_be_o, output, DATA_WIDTH/8 bits: the captured wstrb.
REQ-010 The block SHALL have port wr_stb_o, output, 1 bit: a one-cycle write pulse.
REQ-011 The block SHALL have port rd_addr_o, output, ADDR_WIDTH bits: the captured read address.
REQ-012 The block SHALL have port rd_stb_o, output, 1 bit: a one-cycle read-request pulse.
REQ-013 The block SHALL have port rd_data_i, input, DATA_WIDTH bits: read data from the backend.
REQ-014 The block SHALL have port rd_valid_i, input, 1 bit: qualifies rd_data_i.
REQ-015 The block SHALL have port busy_o, output, 1 bit: high whenever state != IDLE_S.

Function
REQ-016 The FSM SHALL have the states IDLE_S, WAIT_W_S, WAIT_AW_S, WR_S, BRESP_S, RD_S, RD_WAIT_S and RRESP_S, with exactly one transaction in flight.
REQ-017 In IDLE_S: awready=1, wready=1, and arready = !awvalid && !wvalid, so a write has priority over a read presented in the same cycle.
REQ-018 In IDLE_S, on awvalid&&wvalid the block SHALL capture awaddr, wdata and wstrb and go to WR_S.
REQ-019 In IDLE_S, on awvalid only, it SHALL capture awaddr and go to WAIT_W_S.
REQ-020 In IDLE_S, on wvalid only, it SHALL capture wdata and wstrb and go to WAIT_AW_S.
REQ-021 In IDLE_S, with arvalid and no awvalid or wvalid, it SHALL capture araddr and go to RD_S.
REQ-022 In WAIT_W_S: wready=1 and all other readies are 0; on wvalid it SHALL capture the data and go to WR_S.
REQ-023 In WAIT_AW_S: awready=1 and all other readies are 0; on awvalid it SHALL capture the address and go to WR_S.
REQ-024 In WR_S, wr_stb_o SHALL be 1 for exactly this one cycle, with wr_addr_o, wr_data_o and wr_be_o stable; the next state SHALL be BRESP_S.
REQ-025 In BRESP_S: bvalid=1 and bresp=2'b00, held until bready; on the bvalid&&bready cycle the next state SHALL be IDLE_S.
REQ-026 In RD_S, rd_stb_o SHALL be 1 for exactly one cycle with rd_addr_o stable; the next state SHALL be RD_WAIT_S and the timeout counter SHALL be cleared.
REQ-027 In RD_WAIT_S, on rd_valid_i the block SHALL register rd_data_i into rdata, set rresp=2'b00 and go to RRESP_S.
REQ-028 In RD_WAIT_S, otherwise the counter SHALL increment each cycle; on the RD_TIMEOUT-th cycle in RD_WAIT_S without rd_valid_i, the block SHALL set rdata=0 and rresp=2'b10 (SLVERR) and go to RRESP_S.
REQ-029 If rd_valid_i arrives on the final timeout cycle, the data SHALL win and rresp SHALL be OKAY.
REQ-030 In RRESP_S: rvalid=1, with rdata and rresp held until rready; on the rvalid&&rready cycle the next state SHALL be IDLE_S.
REQ-031 rd_valid_i SHALL be ignored outside RD_WAIT_S.
REQ-032 The timeout counter SHALL be $clog2(RD_TIMEOUT)+1 bits wide and SHALL saturate without wrapping.
REQ-033 Latency SHALL be: AW+W handshake at cycle N -> wr_stb_o at N+1 -> bvalid at N+2.
REQ-034 Read latency SHALL be: AR handshake at cycle N -> rd_stb_o at N+1 -> rd_valid_i sampled from N+2 -> rvalid one cycle after rd_valid_i is sampled.
REQ-035 All outputs except the readies SHALL be registered or decoded from the state register only; the readies MAY depend combinationally on awvalid and wvalid.
REQ-036 The outputs SHALL NOT depend combinationally on rd_valid_i.
REQ-037 The valid outputs SHALL never be dependent on ready inputs.

Reset
REQ-038 While rst_i=1: state=IDLE_S, and all readies, bvalid, rvalid, wr_stb_o, rd_stb_o and busy_o SHALL be 0.
REQ-039 While rst_i=1: wr_addr_o, wr_data_o, wr_be_o, rd_addr_o, rdata, bresp, rresp and the counter SHALL be 0.
REQ-040 A reset asserted mid-transaction SHALL abort it without issuing a bresp or rresp, and the next cycle after reset SHALL be IDLE_S.

Verification
REQ-041 Simultaneous AW(0x10)+W(0xDEADBEEF, strb 0xF) -> wr_stb_o at +1 with addr 0x10, data 0xDEADBEEF, be 0xF; bvalid at +2 with bresp 0; bready held low 3 cycles -> bvalid held.
REQ-042 W (0x12345678, strb 0x3) first, AW(0x20) 4 cycles later -> a single wr_stb_o one cycle after AW with addr 0x20, data 0x12345678, be 0x3; arvalid asserted meanwhile -> arready stays 0.
REQ-043 AR(0x40), backend returns 0xCAFEF00D 3 cycles after rd_stb_o -> rvalid with rdata 0xCAFEF00D and rresp 0.
REQ-044 AR(0x44), no rd_valid_i -> rvalid after exactly RD_TIMEOUT cycles in RD_WAIT_S (16) with rdata 0 and rresp 2'b10; a late rd_valid_i afterwards -> ignored.
REQ-045 AW, W and AR all valid in the same idle cycle -> the write completes first (bvalid), then arready=1 and the read proceeds.
REQ-046 rst_i pulsed while in RD_WAIT_S -> no rvalid, busy_o=0 and all outputs 0 the cycle after reset; a following write completes normally.
